cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/tomasula_types.sv | 17 +
 rtl/cdb_arb_pick.sv | 40 ++++
 rtl/cdb_arbiter.sv | 100 ++++++++++
 tb/tb_cdb_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/tomasula_types.sv
// Shared types for the Tomasulo core: CDB requester count and broadcast bus record.
package tomasula_types;

  localparam int NUM_CDB_REQ = 4;

  typedef struct packed {
    logic        valid;
    logic [2:0]  tag;
    logic [31:0] data;
  } cdb_bus_t;

  // Distance of a ROB entry from the head; smaller means older.
  function automatic logic [2:0] rob_age(input logic [2:0] tag, input logic [2:0] head);
    return tag - head;
  endfunction

endpackage

// File: rtl/cdb_arb_pick.sv
// Combinational picker: scans from start, wraps, and keeps the first eligible entry with the smallest key.
module cdb_arb_pick #(
  parameter int N  = 4,
  parameter int KW = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]         elig,
  input  logic [N-1:0][KW-1:0] keys,
  input  logic [IW-1:0]        start,
  output logic [N-1:0]         grant
);

  logic          found;
  logic [KW-1:0] best_key;
  logic [IW-1:0] best_idx;
  logic [IW:0]   pos;
  logic [IW-1:0] idx;

  // Strict less-than keeps the earliest entry in scan order on key ties.
  always_comb begin
    found    = 1'b0;
    best_key = '0;
    best_idx = '0;
    pos      = '0;
    idx      = '0;
    grant    = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, start} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
      idx = pos[IW-1:0];
      if (elig[idx] && (!found || keys[idx] < best_key)) begin
        found    = 1'b1;
        best_key = keys[idx];
        best_idx = idx;
      end
    end
    if (found) grant[best_idx] = 1'b1;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants one functional unit per cycle and registers its broadcast.
// Define CDB_ARB_AGE_EN for oldest-first selection; default is round-robin.
module cdb_arbiter
  import tomasula_types::*;
#(
  parameter int NUM_REQ = NUM_CDB_REQ
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0][2:0]   req_rob_tag,
  input  logic [NUM_REQ-1:0][31:0]  req_data,
  output logic [NUM_REQ-1:0]        grant,
  input  logic [2:0]                head_ptr,
  input  logic [7:0]                allocated_rob_entries,
  input  logic                      flush_in_prog,
  output logic                      cdb_valid,
  output logic [2:0]                cdb_rob_tag,
  output logic [31:0]               cdb_data,
  output logic [7:0]                set_rob_valid
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef CDB_ARB_AGE_EN
  localparam bit AGE_EN = 1'b1;
`else
  localparam bit AGE_EN = 1'b0;
`endif

  logic [NUM_REQ-1:0]      eligible;
  logic [NUM_REQ-1:0]      stale;
  logic [NUM_REQ-1:0]      elig_grant;
  logic [NUM_REQ-1:0]      stale_grant;
  logic [NUM_REQ-1:0][2:0] age_keys;
  logic [NUM_REQ-1:0][2:0] pick_keys;
  logic [IW-1:0]           pick_start;
  logic [IW-1:0]           rr_ptr;
  logic [IW-1:0]           grant_idx;
  logic [IW-1:0]           rr_next;
  logic                    granted_eligible;
  cdb_bus_t                cdb_q;

  // Requests whose ROB entry was freed (e.g. by a flush) are stale and only drained.
  always_comb begin
    eligible = '0;
    stale    = '0;
    age_keys = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req[i] & allocated_rob_entries[req_rob_tag[i]];
      stale[i]    = req[i] & ~allocated_rob_entries[req_rob_tag[i]];
      age_keys[i] = rob_age(req_rob_tag[i], head_ptr);
    end
    pick_keys  = AGE_EN ? age_keys : '0;
    pick_start = AGE_EN ? '0 : rr_ptr;
  end

  cdb_arb_pick #(.N(NUM_REQ), .KW(3)) u_pick_elig (
    .elig  (eligible),
    .keys  (pick_keys),
    .start (pick_start),
    .grant (elig_grant)
  );

  cdb_arb_pick #(.N(NUM_REQ), .KW(3)) u_pick_stale (
    .elig  (stale),
    .keys  ('0),
    .start ('0),
    .grant (stale_grant)
  );

  always_comb begin
    grant = '0;
    if (!rst && !flush_in_prog) grant = (|eligible) ? elig_grant : stale_grant;
    granted_eligible = |(grant & eligible);
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) grant_idx = IW'(i);
    rr_next = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_q  <= '0;
      rr_ptr <= '0;
    end else begin
      if (|grant) rr_ptr <= rr_next;
      cdb_q.valid <= granted_eligible;
      if (granted_eligible) begin
        cdb_q.tag  <= req_rob_tag[grant_idx];
        cdb_q.data <= req_data[grant_idx];
      end
    end
  end

  assign cdb_valid     = cdb_q.valid;
  assign cdb_rob_tag   = cdb_q.tag;
  assign cdb_data      = cdb_q.data;
  assign set_rob_valid = (cdb_q.valid && !rst) ? (8'b1 << cdb_q.tag) : 8'b0;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: grants checked in-cycle, broadcasts popped after the edge.
module tb_cdb_arbiter;
  import tomasula_types::*;

  localparam int N = NUM_CDB_REQ;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req;
  logic [N-1:0][2:0]   req_rob_tag;
  logic [N-1:0][31:0]  req_data;
  logic [N-1:0]        grant;
  logic [2:0]          head_ptr;
  logic [7:0]          allocated_rob_entries;
  logic                flush_in_prog;
  logic                cdb_valid;
  logic [2:0]          cdb_rob_tag;
  logic [31:0]         cdb_data;
  logic [7:0]          set_rob_valid;

  typedef struct {
    logic     chk_payload;
    cdb_bus_t bus;
  } exp_t;

  exp_t     exp_q[$];
  cdb_bus_t last_bus;
  int       checks   = 0;
  int       failures = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(N)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .req                   (req),
    .req_rob_tag           (req_rob_tag),
    .req_data              (req_data),
    .grant                 (grant),
    .head_ptr              (head_ptr),
    .allocated_rob_entries (allocated_rob_entries),
    .flush_in_prog         (flush_in_prog),
    .cdb_valid             (cdb_valid),
    .cdb_rob_tag           (cdb_rob_tag),
    .cdb_data              (cdb_data),
    .set_rob_valid         (set_rob_valid)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] onehot(input cdb_bus_t b);
    return b.valid ? (8'b1 << b.tag) : 8'b0;
  endfunction

  // One cycle: drive, check the grant, predict the broadcast, then pop it after the edge.
  task automatic applyStimulus(input string name, input logic rst_v, input logic flush_v,
                               input logic [N-1:0] req_v, input logic [N-1:0] exp_grant);
    exp_t e;
    int   gi;
    rst           = rst_v;
    flush_in_prog = flush_v;
    req           = req_v;
    #1;
    checkOutput({name, ":grant"}, 64'(grant), 64'(exp_grant));
    checkOutput({name, ":set_rob_valid_now"}, 64'(set_rob_valid),
                rst_v ? 64'd0 : 64'(onehot(last_bus)));
    e.chk_payload = rst_v;
    e.bus         = '0;
    if (!rst_v && exp_grant != '0) begin
      gi = 0;
      for (int i = 0; i < N; i++) if (exp_grant[i]) gi = i;
      if (allocated_rob_entries[req_rob_tag[gi]]) begin
        e.bus.valid   = 1'b1;
        e.bus.tag     = req_rob_tag[gi];
        e.bus.data    = req_data[gi];
        e.chk_payload = 1'b1;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checkOutput({name, ":cdb_valid"}, 64'(cdb_valid), 64'(e.bus.valid));
    if (e.chk_payload) begin
      checkOutput({name, ":cdb_rob_tag"}, 64'(cdb_rob_tag), 64'(e.bus.tag));
      checkOutput({name, ":cdb_data"}, 64'(cdb_data), 64'(e.bus.data));
    end
    checkOutput({name, ":set_rob_valid"}, 64'(set_rob_valid), 64'(onehot(e.bus)));
    last_bus = e.bus;
  endtask

  task automatic setIdentityTags();
    for (int i = 0; i < N; i++) begin
      req_rob_tag[i] = 3'(i);
      req_data[i]    = 32'h1000 + 32'(i);
    end
  endtask

  initial begin
    rst                   = 1'b1;
    req                   = '0;
    flush_in_prog         = 1'b0;
    head_ptr              = 3'd0;
    allocated_rob_entries = 8'hFF;
    setIdentityTags();
    last_bus              = '0;
    @(posedge clk);
    #1;

    applyStimulus("rst0", 1'b1, 1'b0, 4'b1111, 4'b0000);
    applyStimulus("rst0b", 1'b1, 1'b0, 4'b1111, 4'b0000);

    req_rob_tag[0] = 3'd3;
    req_data[0]    = 32'hDEADBEEF;
    applyStimulus("single", 1'b0, 1'b0, 4'b0001, 4'b0001);
    applyStimulus("rst1", 1'b1, 1'b0, 4'b0001, 4'b0000);

    setIdentityTags();
    applyStimulus("rr0", 1'b0, 1'b0, 4'b1111, 4'b0001);
    applyStimulus("rr1", 1'b0, 1'b0, 4'b1111, 4'b0010);
    applyStimulus("rr2", 1'b0, 1'b0, 4'b1111, 4'b0100);
    applyStimulus("rr3", 1'b0, 1'b0, 4'b1111, 4'b1000);
    applyStimulus("rr_wrap", 1'b0, 1'b0, 4'b1111, 4'b0001);

    allocated_rob_entries = 8'hDF;
    req_rob_tag[2] = 3'd5;
    applyStimulus("stale", 1'b0, 1'b0, 4'b0100, 4'b0100);
    req_rob_tag[1] = 3'd5;
    req_rob_tag[2] = 3'd2;
    applyStimulus("stale_vs_elig", 1'b0, 1'b0, 4'b0110, 4'b0100);
    req_rob_tag[3] = 3'd5;
    applyStimulus("stale_low", 1'b0, 1'b0, 4'b1010, 4'b0010);

    allocated_rob_entries = 8'hFF;
    setIdentityTags();
    applyStimulus("flush0", 1'b0, 1'b1, 4'b0011, 4'b0000);
    applyStimulus("flush1", 1'b0, 1'b1, 4'b0011, 4'b0000);
    applyStimulus("flush2", 1'b0, 1'b1, 4'b0011, 4'b0000);
    applyStimulus("flush_end", 1'b0, 1'b0, 4'b0011, 4'b0001);
    applyStimulus("flush_hold", 1'b0, 1'b1, 4'b0011, 4'b0000);
    applyStimulus("idle", 1'b0, 1'b0, 4'b0000, 4'b0000);

    applyStimulus("pre_rst", 1'b0, 1'b0, 4'b0011, 4'b0010);
    applyStimulus("rst_after", 1'b1, 1'b0, 4'b0011, 4'b0000);

    head_ptr       = 3'd6;
    req_rob_tag[0] = 3'd1;
    req_rob_tag[1] = 3'd7;
    req_rob_tag[2] = 3'd0;
`ifdef CDB_ARB_AGE_EN
    applyStimulus("age", 1'b0, 1'b0, 4'b0111, 4'b0010);
`else
    applyStimulus("age_off_rr", 1'b0, 1'b0, 4'b0111, 4'b0001);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
